serial_adder: RTL and testbench

- Parametrised bit-serial adder; generalises the single-bit half-adder cell to WIDTH-bit operands.
- Uses one full-adder cell and one carry flip-flop, processing one bit per clock, LSB first.
- Start/Busy/Done handshake, so it can sit behind a lab datapath or controller that issues one add at a time.
- Trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop, LSB first, Start/Busy/Done handshake.
// Optional subtract mode with signed overflow flag when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_SUB_EN
    output logic             Carry,
    output logic             Overflow
`else
    output logic             Carry
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] areg, breg, res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s, cn, last;

    assign s    = areg[0] ^ breg[0] ^ c;
    assign cn   = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);
    assign last = (cnt == CW'(WIDTH - 1));

    assign Busy = (state != S_IDLE);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (Start) next_state = S_ADD;
            S_ADD:   if (last)  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            areg  <= '0;
            breg  <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            Sum   <= '0;
            Carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            Overflow <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        areg <= A;
                        cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        // Subtraction as A + ~B + 1: invert B once at capture, force carry-in.
                        breg <= Sub ? ~B : B;
                        c    <= Sub ? 1'b1 : CarryIn;
`else
                        breg <= B;
                        c    <= CarryIn;
`endif
                    end
                end
                S_ADD: begin
                    areg <= areg >> 1;
                    breg <= breg >> 1;
                    res  <= {s, res[WIDTH-1:1]};
                    c    <= cn;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        Sum   <= {s, res[WIDTH-1:1]};
                        Carry <= cn;
`ifdef SERIAL_ADDER_SUB_EN
                        // c is the carry into the MSB here, cn the carry out of it.
                        Overflow <= c ^ cn;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CarryIn = 1'b0;
    logic         Busy, Done, Carry;
    logic [W-1:0] Sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         Sub = 1'b0;
    logic         Overflow;
`endif

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .A(A),
        .B(B),
        .CarryIn(CarryIn),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub(Sub),
`endif
        .Busy(Busy),
        .Done(Done),
        .Sum(Sum),
`ifdef SERIAL_ADDER_SUB_EN
        .Carry(Carry),
        .Overflow(Overflow)
`else
        .Carry(Carry)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: {carry, sum} of A + B' + cin as a (W+1)-bit integer.
    function automatic logic [63:0] model_full(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
        logic [63:0] bb, ci;
        bb = sub ? 64'(~b) : 64'(b);
        ci = sub ? 64'd1 : 64'(cin);
        return (64'(a) + bb + ci) & ((64'd1 << (W + 1)) - 1);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic [W-1:0] sum);
        logic [W-1:0] bb;
        bb = sub ? ~b : b;
        return (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    endfunction

    // Issues one operation, scrambles operands while busy, and checks timing and result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic hold_start, input string tag);
        logic [63:0]  full;
        logic [W-1:0] prev_sum;
        logic         prev_c;
        logic         hold_ok;
        int unsigned  n, busy_cnt;
        full = model_full(a, b, cin, sub);
        A = a;
        B = b;
        CarryIn = cin;
`ifdef SERIAL_ADDER_SUB_EN
        Sub = sub;
`endif
        Start = 1'b1;
        step();
        check({tag, " busy@accept"}, 64'(Busy), 64'd1);
        if (!hold_start) Start = 1'b0;
        prev_sum = Sum;
        prev_c = Carry;
        hold_ok = 1'b1;
        n = 0;
        busy_cnt = 0;
        while (!Done && n < 4 * W) begin
            if (Busy) busy_cnt++;
            if (Sum !== prev_sum || Carry !== prev_c) hold_ok = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            CarryIn = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            Sub = 1'($urandom);
`endif
            step();
            n++;
        end
        if (Busy) busy_cnt++;
        check({tag, " latency"}, 64'(n), 64'(W));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, " sum hold in add"}, 64'(hold_ok), 64'd1);
        check({tag, " sum"}, 64'(Sum), full & ((64'd1 << W) - 1));
        check({tag, " carry"}, 64'(Carry), 64'(full[W]));
`ifdef SERIAL_ADDER_SUB_EN
        check({tag, " overflow"}, 64'(Overflow), 64'(model_ovf(a, b, sub, W'(full))));
`endif
        step();
        check({tag, " done pulse"}, 64'(Done), 64'd0);
        check({tag, " idle busy"}, 64'(Busy), 64'd0);
        check({tag, " idle sum"}, 64'(Sum), full & ((64'd1 << W) - 1));
    endtask

    initial begin
        logic        saw_done;
        logic [W-1:0] ra, rb;
        logic        rc, rs;

        Reset = 1'b1;
        step();
        step();
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset sum", 64'(Sum), 64'd0);
        check("reset carry", 64'(Carry), 64'd0);
`ifdef SERIAL_ADDER_SUB_EN
        check("reset overflow", 64'(Overflow), 64'd0);
`endif
        Reset = 1'b0;
        step();

        do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "ff+01");
        for (int i = 0; i < 3; i++) begin
            step();
            check("ff+01 idle hold sum", 64'(Sum), 64'h00);
            check("ff+01 idle hold carry", 64'(Carry), 64'd1);
        end
        do_op(8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, "7f+80+1");
        check("7f+80+1 const sum", 64'(Sum), 64'h00);
        do_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0, "35+4a");
        check("35+4a const sum", 64'(Sum), 64'h7F);
        check("35+4a const carry", 64'(Carry), 64'd0);

        // Start held high: the following op must be accepted at edge W+2.
        do_op(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, "held start");
        check("held start const sum", 64'(Sum), 64'hE2);
        do_op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, "reaccept");

        // Reset in the middle of an add.
        A = 8'hFF;
        B = 8'hFF;
        CarryIn = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        repeat (4) step();
        Reset = 1'b1;
        step();
        check("midreset busy", 64'(Busy), 64'd0);
        check("midreset done", 64'(Done), 64'd0);
        check("midreset sum", 64'(Sum), 64'd0);
        check("midreset carry", 64'(Carry), 64'd0);
        Reset = 1'b0;
        saw_done = 1'b0;
        repeat (W + 4) begin
            step();
            if (Done) saw_done = 1'b1;
        end
        check("midreset no done", 64'(saw_done), 64'd0);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, "12+34");
        check("12+34 const sum", 64'(Sum), 64'h46);

        // Reset and Start together: Start discarded.
        Reset = 1'b1;
        Start = 1'b1;
        step();
        check("reset+start busy", 64'(Busy), 64'd0);
        check("reset+start sum", 64'(Sum), 64'd0);
        Reset = 1'b0;
        Start = 1'b0;
        step();
        check("reset+start stays idle", 64'(Busy), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, "05-07");
        check("05-07 const sum", 64'(Sum), 64'hFE);
        check("05-07 const ovf", 64'(Overflow), 64'd0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, "80-01");
        check("80-01 const sum", 64'(Sum), 64'h7F);
        check("80-01 const ovf", 64'(Overflow), 64'd1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "7f+01");
        check("7f+01 const ovf", 64'(Overflow), 64'd1);
`endif

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, 1'b0, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
